sparse_bitplane_sched: RTL and testbench

Bit-serial scheduler for the SparseCIM macro. It accepts one vector of multi-bit activations and drives it onto the macro word lines one bit plane at a time, MSB first. It collects each adder-tree partial sum and shift-accumulates it into the dot-product result. When enabled, it also skips all-zero bit planes, which is the sparsity saving. It sits between the activation buffer and the macro and generalises the fixed 4-phase shift-accumulator into a controller with a handshake on both sides.

---
 rtl/sparse_cim_pkg.sv | 9 +
 rtl/sparse_shift_acc.sv | 23 ++
 rtl/sparse_bitplane_sched.sv | 133 +++++++++++++
 tb/tb_sparse_bitplane_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_cim_pkg.sv
// Shared defaults and FSM state encoding for the SparseCIM bit-serial scheduler.
package sparse_cim_pkg;
  localparam int ROWS   = 16;
  localparam int ACT_W  = 4;
  localparam int PSUM_W = $clog2(ROWS) + 1;
  localparam int OUT_W  = PSUM_W + ACT_W - 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} sched_state_t;
endpackage

// File: rtl/sparse_shift_acc.sv
// Shift-accumulator: adds (zero-extended psum << shift) into acc, modulo 2^OUT_W.
module sparse_shift_acc #(
  parameter int PSUM_W = 5,
  parameter int OUT_W  = 8,
  parameter int SH_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add_en,
  input  logic [SH_W-1:0]   shift,
  input  logic [PSUM_W-1:0] psum,
  output logic [OUT_W-1:0]  acc
);
  logic [OUT_W-1:0] psum_ext;
  assign psum_ext = OUT_W'(psum);

  // Clear at vector start, otherwise accumulate the weighted partial sum.
  always_ff @(posedge clk) begin
    if (rst || clr)  acc <= '0;
    else if (add_en) acc <= acc + (psum_ext << shift);
  end
endmodule

// File: rtl/sparse_bitplane_sched.sv
// Bit-serial activation scheduler: drives one bit plane per macro fire, MSB
// first, and shift-accumulates the returned partial sums.
// Optional feature macro: SPARSE_PLANE_SKIP_EN (skip all-zero bit planes).
module sparse_bitplane_sched
  import sparse_cim_pkg::*;
#(
  parameter int ROWS   = sparse_cim_pkg::ROWS,
  parameter int ACT_W  = sparse_cim_pkg::ACT_W,
  parameter int PSUM_W = $clog2(ROWS) + 1,
  parameter int OUT_W  = PSUM_W + ACT_W - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  act_valid,
  output logic                  act_ready,
  input  logic [ROWS*ACT_W-1:0] act_data,
  output logic [ROWS-1:0]       wl_bits,
  output logic                  wl_valid,
  input  logic [PSUM_W-1:0]     psum,
  input  logic                  psum_valid,
  output logic [OUT_W-1:0]      res_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy,
  output logic                  err
);
  localparam int SH_W = (ACT_W > 1) ? $clog2(ACT_W) : 1;

`ifdef SPARSE_PLANE_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  sched_state_t          state, state_nxt;
  logic [ROWS*ACT_W-1:0] act_reg;
  logic [SH_W-1:0]       b;
  logic [ROWS-1:0]       plane;
  logic [OUT_W-1:0]      acc;
  logic                  ready_q;
  logic                  accept, acc_clr, add_en, b_dec, err_set;

  // Bit plane b: one bit from every row's activation.
  for (genvar r = 0; r < ROWS; r++) begin : g_plane
    logic [ACT_W-1:0] act_r;
    assign act_r    = act_reg[r*ACT_W +: ACT_W];
    assign plane[r] = act_r[b];
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    wl_valid  = 1'b0;
    accept    = 1'b0;
    acc_clr   = 1'b0;
    add_en    = 1'b0;
    b_dec     = 1'b0;
    case (state)
      IDLE: begin
        if (act_valid && act_ready) begin
          accept    = 1'b1;
          acc_clr   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (SKIP && (plane == '0)) begin
          if (b == '0) state_nxt = DONE;
          else         b_dec     = 1'b1;
        end else begin
          wl_valid  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (psum_valid) begin
          add_en = 1'b1;
          if (b == '0) state_nxt = DONE;
          else begin
            b_dec     = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      DONE: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A psum can only be legitimately expected while waiting; IDLE ones may be
  // stragglers from an abandoned vector and are ignored.
  assign err_set = psum_valid && ((state == ISSUE) || (state == DONE));

  // State, operand and bit-index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      act_reg <= '0;
      b       <= '0;
      ready_q <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= 1'b1;
      if (err_set) err <= 1'b1;
      if (accept) begin
        act_reg <= act_data;
        b       <= SH_W'(ACT_W - 1);
      end else if (b_dec) begin
        b <= b - 1'b1;
      end
    end
  end

  sparse_shift_acc #(.PSUM_W(PSUM_W), .OUT_W(OUT_W), .SH_W(SH_W)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .add_en (add_en),
    .shift  (b),
    .psum   (psum),
    .acc    (acc)
  );

  // ready_q holds act_ready low for the first cycle after reset.
  assign act_ready = (state == IDLE) && ready_q;
  assign busy      = (state != IDLE);
  assign wl_bits   = ((state == ISSUE) || (state == WAIT)) ? plane : '0;
  assign res_valid = (state == DONE);
  assign res_data  = res_valid ? acc : '0;
endmodule

// File: tb/tb_sparse_bitplane_sched.sv
// Self-checking bench for sparse_bitplane_sched (honours SPARSE_PLANE_SKIP_EN).
module tb_sparse_bitplane_sched;
  import sparse_cim_pkg::*;

  localparam int VW = ROWS * ACT_W;
`ifdef SPARSE_PLANE_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, act_valid, act_ready, wl_valid, psum_valid;
  logic              res_valid, res_ready, busy, err;
  logic [VW-1:0]     act_data;
  logic [ROWS-1:0]   wl_bits;
  logic [PSUM_W-1:0] psum;
  logic [OUT_W-1:0]  res_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sparse_bitplane_sched dut (
    .clk(clk), .rst(rst), .act_valid(act_valid), .act_ready(act_ready),
    .act_data(act_data), .wl_bits(wl_bits), .wl_valid(wl_valid), .psum(psum),
    .psum_valid(psum_valid), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy), .err(err)
  );

  typedef struct {
    logic [VW-1:0]    vec;
    int               lat;
    int               hold;
    logic [OUT_W-1:0] res;
    int               pulses;
    int               cyc;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: plane b is bit b of every row.
  function automatic logic [ROWS-1:0] plane_of(input logic [VW-1:0] v, input int b);
    logic [ROWS-1:0] p;
    for (int r = 0; r < ROWS; r++) p[r] = v[r*ACT_W + b];
    return p;
  endfunction

  function automatic int popcnt(input logic [ROWS-1:0] p);
    int n = 0;
    for (int r = 0; r < ROWS; r++) n += p[r];
    return n;
  endfunction

  // Dot product against all-ones weights is just the activation sum.
  function automatic logic [OUT_W-1:0] model_res(input logic [VW-1:0] v);
    int s = 0;
    for (int r = 0; r < ROWS; r++) s += int'(v[r*ACT_W +: ACT_W]);
    return OUT_W'(s);
  endfunction

  function automatic int model_pulses(input logic [VW-1:0] v);
    int n = 0;
    for (int b = 0; b < ACT_W; b++) if (!(SKIP && plane_of(v, b) == '0)) n++;
    return n;
  endfunction

  function automatic int model_cyc(input logic [VW-1:0] v, input int lat);
    int c = 1;
    for (int b = 0; b < ACT_W; b++) c += (SKIP && plane_of(v, b) == '0) ? 1 : 1 + lat;
    return c;
  endfunction

  // Drives one vector, emulates the macro (psum = popcount of the plane,
  // latency lat), and checks planes, pulse count, result latency and value.
  task automatic run_vec(input string nm, input logic [VW-1:0] v, input int lat,
                         input int hold, input bit inject, input logic [OUT_W-1:0] exp_res,
                         input int exp_pulses, input int exp_cyc, input bit exp_err);
    logic [ROWS-1:0] expq[$];
    int cyc, due, npulse, rescyc;
    bit outstanding;
    logic [PSUM_W-1:0] pend;
    for (int b = ACT_W - 1; b >= 0; b--)
      if (!(SKIP && plane_of(v, b) == '0)) expq.push_back(plane_of(v, b));
    due = -1; npulse = 0; rescyc = -1; outstanding = 0; pend = '0;
    res_ready = (hold == 0);
    @(negedge clk);
    chk({nm, "_act_ready"}, act_ready, 1);
    act_data = v; act_valid = 1'b1;
    @(posedge clk); #1;
    act_valid = 1'b0;
    cyc = 1;
    for (int k = 0; k < 300; k++) begin
      psum_valid = (cyc == due);
      psum = (cyc == due) ? pend : '0;
      @(negedge clk);
      if (wl_valid) begin
        npulse++;
        chk({nm, "_no_overlap"}, outstanding, 0);
        if (expq.size() == 0) chk({nm, "_extra_pulse"}, 1, 0);
        else begin
          pend = PSUM_W'(popcnt(expq[0]));
          chk({nm, "_wl_bits"}, wl_bits, expq.pop_front());
        end
        due = cyc + lat;
        outstanding = 1;
      end
      if (res_valid) begin rescyc = cyc; break; end
      @(posedge clk); #1;
      if (cyc == due) outstanding = 0;
      cyc++;
    end
    psum_valid = 1'b0;
    if (rescyc < 0) begin
      chk({nm, "_res_timeout"}, 0, 1);
      return;
    end
    chk({nm, "_pulses"}, npulse, exp_pulses);
    chk({nm, "_res_cyc"}, rescyc, exp_cyc);
    chk({nm, "_res_data"}, res_data, exp_res);
    // Consumer stall: result must hold, and no new vector is accepted.
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      act_valid = 1'b1; act_data = ~v;
      psum_valid = inject && (h == 0);
      @(negedge clk);
      chk({nm, "_hold_valid"}, res_valid, 1);
      chk({nm, "_hold_data"}, res_data, exp_res);
      chk({nm, "_hold_ready"}, act_ready, 0);
    end
    @(posedge clk); #1;
    act_valid = 1'b0; psum_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_idle_res_valid"}, res_valid, 0);
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_err"}, err, exp_err);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_act_ready"}, act_ready, 0);
    chk({nm, "_wl_valid"}, wl_valid, 0);
    chk({nm, "_wl_bits"}, wl_bits, 0);
    chk({nm, "_res_valid"}, res_valid, 0);
    chk({nm, "_res_data"}, res_data, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"}, err, 0);
  endtask

  vec_t tbl[5];

  initial begin
    logic [VW-1:0] v;
    int lat;
    tbl[0] = '{{VW{1'b1}}, 1, 0, OUT_W'(240), 4, 9};
    tbl[1] = '{VW'(64'hA), 1, 0, OUT_W'(10), SKIP ? 2 : 4, SKIP ? 7 : 9};
    tbl[2] = '{'0, 1, 0, OUT_W'(0), SKIP ? 0 : 4, SKIP ? 5 : 9};
    tbl[3] = '{{VW{1'b1}}, 3, 5, OUT_W'(240), 4, 17};
    tbl[4] = '{VW'(64'h0123_4567_89AB_CDEF), 2, 0, OUT_W'(120), 4, 13};

    rst = 1'b1; act_valid = 1'b0; act_data = '0; psum = '0;
    psum_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_low_after_rst", act_ready, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++)
      run_vec($sformatf("tbl%0d", i), tbl[i].vec, tbl[i].lat, tbl[i].hold, 1'b0,
              tbl[i].res, tbl[i].pulses, tbl[i].cyc, 1'b0);

    // Reset during WAIT, with a stale psum arriving after reset.
    @(negedge clk);
    act_data = {VW{1'b1}}; act_valid = 1'b1;
    @(posedge clk); #1;
    act_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_in_wait", busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    @(posedge clk); #1;
    psum_valid = 1'b1; psum = PSUM_W'(16);
    @(posedge clk); #1;
    psum_valid = 1'b0;
    @(negedge clk);
    chk("midrst_err", err, 0);
    chk("midrst_ready", act_ready, 1);
    @(posedge clk); #1;
    run_vec("after_rst", tbl[0].vec, 1, 0, 1'b0, tbl[0].res, tbl[0].pulses, tbl[0].cyc, 1'b0);

    // Randomised vectors against the reference model, some rows masked to
    // create empty bit planes.
    for (int i = 0; i < 20; i++) begin
      logic [ACT_W-1:0] mask;
      mask = ACT_W'($urandom_range(0, (1 << ACT_W) - 1));
      for (int r = 0; r < ROWS; r++)
        v[r*ACT_W +: ACT_W] = ($urandom_range(0, 3) == 0) ? '0 :
                              (ACT_W'($urandom_range(0, (1 << ACT_W) - 1)) & mask);
      lat = $urandom_range(1, 3);
      run_vec($sformatf("rnd%0d", i), v, lat, $urandom_range(0, 2), 1'b0,
              model_res(v), model_pulses(v), model_cyc(v, lat), 1'b0);
    end

    // psum in DONE is a protocol error; it stays sticky until reset.
    run_vec("err_inject", tbl[4].vec, 2, 2, 1'b1, tbl[4].res, tbl[4].pulses, tbl[4].cyc, 1'b1);
    run_vec("err_sticky", tbl[1].vec, 1, 0, 1'b0, tbl[1].res, tbl[1].pulses, tbl[1].cyc, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("err_cleared", err, 0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
